// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imm_pkg
// Purpose : Shared types and opcode constants for RISC-V immediate decode.
//           Holds the immediate format code and the base opcodes that carry
//           an immediate operand.
// Revision: 1.0 - initial release
// ============================================================================
package imm_pkg;

  // Immediate format code seen by the operand mux and the pipeline register
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  // Map a major opcode to the immediate format it uses; unknown -> NONE
  function automatic fmt_t opcode_to_fmt(input logic [6:0] opcode);
    fmt_t f;
    f = FMT_NONE;
    case (opcode)
      OP_LOAD,
      OP_IMM,
      OP_IMM32,
      OP_JALR,
      OP_SYSTEM,
      OP_MISC_MEM: f = FMT_I;
      OP_STORE:    f = FMT_S;
      OP_BRANCH:   f = FMT_B;
      OP_LUI,
      OP_AUIPC:    f = FMT_U;
      OP_JAL:      f = FMT_J;
      default:     f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module  : imm_extract
// Purpose : Pulls the five RISC-V immediate fields (I/S/B/U/J) out of an
//           instruction word and sign-extends each to xlen from instr[31].
// Revision: 1.0 - initial release
// ============================================================================
module imm_extract #(
  parameter int xlen = 64
) (
  input  logic [31:0]     instr,
  output logic [xlen-1:0] imm_i,
  output logic [xlen-1:0] imm_s,
  output logic [xlen-1:0] imm_b,
  output logic [xlen-1:0] imm_u,
  output logic [xlen-1:0] imm_j
);

  // Raw fields held as signed so the width cast below sign-extends them
  logic signed [11:0] w_raw_i;
  logic signed [11:0] w_raw_s;
  logic signed [12:0] w_raw_b;
  logic signed [31:0] w_raw_u;
  logic signed [20:0] w_raw_j;

  assign w_raw_i = instr[31:20];
  assign w_raw_s = {instr[31:25], instr[11:7]};
  assign w_raw_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_raw_u = {instr[31:12], 12'b0};
  assign w_raw_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // U keeps going above bit 31 on RV64 (LUI/AUIPC results are sign-extended)
  assign imm_i = xlen'(w_raw_i);
  assign imm_s = xlen'(w_raw_s);
  assign imm_b = xlen'(w_raw_b);
  assign imm_u = xlen'(w_raw_u);
  assign imm_j = xlen'(w_raw_j);

endmodule : imm_extract
`default_nettype wire

// File: rtl/immediate_gen.sv
`default_nettype none
// ============================================================================
// Module  : immediate_gen
// Purpose : Decode-stage immediate generator. Provides zero-latency memory
//           and branch offsets, the format-selected immediate and format
//           code, plus a registered copy for the decode/execute boundary.
// Revision: 1.0 - initial release
// ============================================================================
module immediate_gen
  import imm_pkg::*;
#(
  parameter int xlen = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [31:0]     instr,
  output logic [xlen-1:0] imm_mem,
  output logic [xlen-1:0] imm_branch,
  output logic [xlen-1:0] imm_sel,
  output logic [2:0]      fmt,
  output logic [xlen-1:0] imm_q,
  output logic [2:0]      fmt_q
);

  logic [xlen-1:0] imm_i;
  logic [xlen-1:0] imm_s;
  logic [xlen-1:0] imm_b;
  logic [xlen-1:0] imm_u;
  logic [xlen-1:0] imm_j;
  logic [6:0]      opcode;
  fmt_t            fmt_dec;
  logic [xlen-1:0] imm_d;
  logic [2:0]      fmt_d;

  imm_extract #(
    .xlen (xlen)
  ) u_imm_extract (
    .instr (instr),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  assign opcode = instr[6:0];

  // Opcode decode: which immediate format this instruction carries
  always_comb begin
    fmt_dec = opcode_to_fmt(opcode);
  end

  assign fmt = fmt_dec;

  // Address-adder offset: stores use S, everything else is treated as I
  always_comb begin
    imm_mem = imm_i;
    if (opcode == OP_STORE) begin
      imm_mem = imm_s;
    end
  end

  // Branch target adder always sees the B-field; the opcode gates use later
  assign imm_branch = imm_b;

  // Operand-mux immediate; shifts are not special-cased, so shamt carries
  // the raw I-field including funct bits
  always_comb begin
    imm_sel = '0;
    case (fmt_dec)
      FMT_I:   imm_sel = imm_i;
      FMT_S:   imm_sel = imm_s;
      FMT_B:   imm_sel = imm_b;
      FMT_U:   imm_sel = imm_u;
      FMT_J:   imm_sel = imm_j;
      default: imm_sel = '0;
    endcase
  end

  // Next value for the pipeline register: load on en, otherwise hold
  always_comb begin
    imm_d = imm_q;
    fmt_d = fmt_q;
    if (en) begin
      imm_d = imm_sel;
      fmt_d = fmt_dec;
    end
  end

  // Pipeline register; reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_q <= '0;
      fmt_q <= FMT_NONE;
    end else begin
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

endmodule : immediate_gen
`default_nettype wire

// File: tb/tb_immediate_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_immediate_gen
// Purpose : Directed-vector bench for immediate_gen with a scoreboard queue
//           and an independent monitor that compares on the falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_immediate_gen;

  localparam int XLEN = 64;

  localparam logic [5:0] C_MEM  = 6'b000001;
  localparam logic [5:0] C_BR   = 6'b000010;
  localparam logic [5:0] C_SEL  = 6'b000100;
  localparam logic [5:0] C_FMT  = 6'b001000;
  localparam logic [5:0] C_IMMQ = 6'b010000;
  localparam logic [5:0] C_FMTQ = 6'b100000;

  typedef struct {
    string      name;
    int         due;
    logic [5:0] chk;
    logic [63:0] mem;
    logic [63:0] br;
    logic [63:0] sel;
    logic [2:0]  fmt;
    logic [63:0] immq;
    logic [2:0]  fmtq;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            en;
  logic [31:0]     instr;
  logic [XLEN-1:0] imm_mem;
  logic [XLEN-1:0] imm_branch;
  logic [XLEN-1:0] imm_sel;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      fmt_q;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  immediate_gen #(
    .xlen (XLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .instr      (instr),
    .imm_mem    (imm_mem),
    .imm_branch (imm_branch),
    .imm_sel    (imm_sel),
    .fmt        (fmt),
    .imm_q      (imm_q),
    .fmt_q      (fmt_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string n, input string f, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", n, f, act, exp);
    end
  endtask

  // Monitor: compare every entry that falls due in this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s.late actual_cycle=%0d expected_cycle=%0d", e.name, cyc, e.due);
      end else begin
        if (e.chk & C_MEM)  cmp(e.name, "imm_mem",    imm_mem,    e.mem);
        if (e.chk & C_BR)   cmp(e.name, "imm_branch", imm_branch, e.br);
        if (e.chk & C_SEL)  cmp(e.name, "imm_sel",    imm_sel,    e.sel);
        if (e.chk & C_FMT)  cmp(e.name, "fmt",        {61'd0, fmt},   {61'd0, e.fmt});
        if (e.chk & C_IMMQ) cmp(e.name, "imm_q",      imm_q,      e.immq);
        if (e.chk & C_FMTQ) cmp(e.name, "fmt_q",      {61'd0, fmt_q}, {61'd0, e.fmtq});
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge
  task automatic drive(input logic r, input logic e, input logic [31:0] i);
    @(posedge clk);
    #1;
    rst   = r;
    en    = e;
    instr = i;
  endtask

  // Expected combinational outputs, due in the current cycle
  task automatic push_comb(input string n, input logic [5:0] chk, input logic [63:0] mem,
                           input logic [63:0] br, input logic [63:0] sel, input logic [2:0] f);
    exp_t e;
    e.name = n; e.due = cyc; e.chk = chk;
    e.mem = mem; e.br = br; e.sel = sel; e.fmt = f;
    e.immq = '0; e.fmtq = '0;
    q.push_back(e);
  endtask

  // Expected registered outputs, due after the next rising edge
  task automatic push_reg(input string n, input logic [63:0] iq, input logic [2:0] fq);
    exp_t e;
    e.name = n; e.due = cyc + 1; e.chk = C_IMMQ | C_FMTQ;
    e.mem = '0; e.br = '0; e.sel = '0; e.fmt = '0;
    e.immq = iq; e.fmtq = fq;
    q.push_back(e);
  endtask

  initial begin
    int guard;
    rst   = 1'b1;
    en    = 1'b0;
    instr = 32'h0;

    // Reset state of the pipeline register
    drive(1'b1, 1'b0, 32'h0000_0033);
    push_reg("reset", 64'd0, 3'd0);

    // Combinational decode vectors (en held low)
    drive(1'b0, 1'b0, 32'h0220_8463);
    push_comb("beq_40", C_MEM | C_BR | C_SEL | C_FMT, 64'd34, 64'd40, 64'd40, 3'd3);
    drive(1'b0, 1'b0, 32'hfe62_8ce3);
    push_comb("beq_m8", C_BR | C_SEL | C_FMT, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8,
              64'hFFFF_FFFF_FFFF_FFF8, 3'd3);
    drive(1'b0, 1'b0, 32'h0221_3103);
    push_comb("ld_34", C_MEM | C_SEL | C_FMT, 64'd34, 64'h0, 64'd34, 3'd1);
    drive(1'b0, 1'b0, 32'hec62_ba23);
    push_comb("sd_m300", C_MEM | C_SEL | C_FMT, 64'hFFFF_FFFF_FFFF_FED4, 64'h0,
              64'hFFFF_FFFF_FFFF_FED4, 3'd2);
    drive(1'b0, 1'b0, 32'h8000_00b7);
    push_comb("lui_neg", C_SEL | C_FMT, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 3'd4);
    drive(1'b0, 1'b0, 32'h0000_0033);
    push_comb("add_none", C_MEM | C_BR | C_SEL | C_FMT, 64'h0, 64'h0, 64'h0, 3'd0);
    drive(1'b0, 1'b0, 32'h0080_006f);
    push_comb("jal_8", C_SEL | C_FMT, 64'h0, 64'h0, 64'd8, 3'd5);
    drive(1'b0, 1'b0, 32'h0000_1097);
    push_comb("auipc_1", C_SEL | C_FMT, 64'h0, 64'h0, 64'h1000, 3'd4);
    drive(1'b0, 1'b0, 32'hffc0_8067);
    push_comb("jalr_m4", C_MEM | C_SEL | C_FMT, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,
              64'hFFFF_FFFF_FFFF_FFFC, 3'd1);
    drive(1'b0, 1'b0, 32'h8000_0013);
    push_comb("addi_min", C_MEM | C_BR | C_SEL | C_FMT, 64'hFFFF_FFFF_FFFF_F800,
              64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_F800, 3'd1);
    drive(1'b0, 1'b0, 32'h03f0_9093);
    push_comb("slli_63", C_SEL | C_FMT, 64'h0, 64'h0, 64'd63, 3'd1);

    // Register stage
    drive(1'b1, 1'b0, 32'h0221_3103);
    push_reg("rst_1cyc", 64'd0, 3'd0);
    drive(1'b0, 1'b1, 32'h0221_3103);
    push_reg("load_34", 64'd34, 3'd1);
    drive(1'b0, 1'b0, 32'h8000_00b7);
    push_comb("hold_comb", C_FMT, 64'h0, 64'h0, 64'h0, 3'd4);
    push_reg("hold_34", 64'd34, 3'd1);
    drive(1'b0, 1'b0, 32'h0000_0033);
    push_reg("hold_34b", 64'd34, 3'd1);
    drive(1'b1, 1'b1, 32'h8000_00b7);
    push_reg("rst_over_en", 64'd0, 3'd0);
    drive(1'b0, 1'b1, 32'h0080_006f);
    push_reg("load_jal", 64'd8, 3'd5);
    drive(1'b0, 1'b0, 32'h0000_0033);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_immediate_gen
`default_nettype wire
